// File: rtl/mult_pkg.sv
// Shared types for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_sub_ext.sv
// (WIDTH+1)-bit adder/subtractor: ext(a) +/- ext(b), where ext() sign-extends in
// signed mode and zero-extends otherwise. When en is low the addend is zero.
module add_sub_ext #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  input  logic             sub,
  input  logic             en,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0] w_a_ext;
  logic [WIDTH:0] w_b_ext;
  logic [WIDTH:0] w_addend;
  logic [WIDTH:0] w_cin;

  assign w_a_ext  = {sgn & a[WIDTH-1], a};
  // Subtraction is two's-complement: invert here, add the carry-in below.
  assign w_b_ext  = {sgn & b[WIDTH-1], b} ^ {(WIDTH+1){sub}};
  assign w_addend = en ? w_b_ext : '0;
  assign w_cin    = {{WIDTH{1'b0}}, en & sub};
  assign sum      = w_a_ext + w_addend + w_cin;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier: full 2*WIDTH-bit product in WIDTH iterations,
// signed (two's-complement) or unsigned per operation.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   multiplicand_i,
  input  logic [WIDTH-1:0]   multiplier_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o,
  output logic               x_o
);

  localparam int CW = $clog2(WIDTH);

  state_t          r_state;
  state_t          w_state_next;
  logic            w_accept;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic            r_x;
  logic            r_sgn;
  logic [CW-1:0]   r_cnt;
  logic            w_sub;
  logic [WIDTH:0]  w_sum;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (r_cnt == '0) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (start_i) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // The final iteration weighs the multiplier MSB negatively in signed mode.
  assign w_sub = r_sgn & (r_cnt == '0);

  add_sub_ext #(
    .WIDTH(WIDTH)
  ) u_add_sub_ext (
    .a   (r_a),
    .b   (r_s),
    .sgn (r_sgn),
    .sub (w_sub),
    .en  (r_b[0]),
    .sum (w_sum)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_s   <= '0;
      r_x   <= 1'b0;
      r_sgn <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_a   <= '0;
      r_x   <= 1'b0;
      r_b   <= multiplier_i;
      r_s   <= multiplicand_i;
      r_sgn <= signed_i;
      r_cnt <= CW'(WIDTH - 1);
    end else if (r_state == RUN) begin
      // Shift {X, A, B} right by one with the new sum entering from the top.
      r_a <= {w_sum[WIDTH], w_sum[WIDTH-1:1]};
      r_b <= {w_sum[0], r_b[WIDTH-1:1]};
      r_x <= w_sum[WIDTH];
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign busy_o    = (r_state == RUN);
  assign done_o    = (r_state == DONE);
  assign product_o = {r_a, r_b};
  assign x_o       = r_x;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: WIDTH=8 and WIDTH=32 instances against an
// arithmetic product model plus directed literal expectations.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        st8 = 1'b0, sg8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, x8;
  logic [15:0] prod8;

  logic        st32 = 1'b0, sg32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32, x32;
  logic [63:0] prod32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(8)) dut8 (
    .Clk(clk), .Reset(rst), .start_i(st8), .signed_i(sg8),
    .multiplicand_i(a8), .multiplier_i(b8),
    .busy_o(busy8), .done_o(done8), .product_o(prod8), .x_o(x8)
  );

  shift_add_multiplier #(.WIDTH(32)) dut32 (
    .Clk(clk), .Reset(rst), .start_i(st32), .signed_i(sg32),
    .multiplicand_i(a32), .multiplier_i(b32),
    .busy_o(busy32), .done_o(done32), .product_o(prod32), .x_o(x32)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Plain arithmetic product of two w-bit operands, truncated to 2*w bits.
  function automatic logic [63:0] model_mul(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input bit s);
    logic [63:0] ta, tb, mask;
    ta = {32'b0, a};
    tb = {32'b0, b};
    if (s) begin
      ta = $signed(ta << (64 - w)) >>> (64 - w);
      tb = $signed(tb << (64 - w)) >>> (64 - w);
    end
    mask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    return (ta * tb) & mask;
  endfunction

  // Transaction-level model: an accepted start yields WIDTH busy cycles, then a
  // single done cycle carrying the product, which holds until the next start.
  int          m8_left = 0, m32_left = 0;
  bit          m8_done = 0, m32_done = 0;
  bit          m8_valid = 1, m32_valid = 1;
  logic [63:0] m8_prod = '0, m32_prod = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m8_left <= 0;  m8_done <= 0;  m8_valid <= 1;  m8_prod <= '0;
      m32_left <= 0; m32_done <= 0; m32_valid <= 1; m32_prod <= '0;
    end else begin
      if (m8_left > 0) begin
        m8_left <= m8_left - 1;
        m8_done <= (m8_left == 1);
        if (m8_left == 1) m8_valid <= 1;
      end else begin
        m8_done <= 0;
        if (st8) begin
          m8_left  <= 8;
          m8_valid <= 0;
          m8_prod  <= model_mul(8, {24'b0, a8}, {24'b0, b8}, sg8);
        end
      end
      if (m32_left > 0) begin
        m32_left <= m32_left - 1;
        m32_done <= (m32_left == 1);
        if (m32_left == 1) m32_valid <= 1;
      end else begin
        m32_done <= 0;
        if (st32) begin
          m32_left  <= 32;
          m32_valid <= 0;
          m32_prod  <= model_mul(32, a32, b32, sg32);
        end
      end
    end
  end

  // X mirrors the top bit of A after every iteration, so at rest it is the product MSB.
  always @(negedge clk) begin
    check("busy8", 64'(busy8), 64'(m8_left > 0));
    check("done8", 64'(done8), 64'(m8_done));
    if (m8_valid) begin
      check("prod8", 64'(prod8), m8_prod);
      check("x8", 64'(x8), 64'(m8_prod[15]));
    end
    check("busy32", 64'(busy32), 64'(m32_left > 0));
    check("done32", 64'(done32), 64'(m32_done));
    if (m32_valid) begin
      check("prod32", prod32, m32_prod);
      check("x32", 64'(x32), 64'(m32_prod[63]));
    end
  end

  task automatic wait8(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done8 && n < 200);
  endtask

  task automatic wait32(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done32 && n < 200);
  endtask

  task automatic run8(input string nm, input bit s, input logic [7:0] a,
                      input logic [7:0] b, input logic [15:0] exp);
    int n;
    @(negedge clk); st8 = 1'b1; sg8 = s; a8 = a; b8 = b;
    @(negedge clk); st8 = 1'b0;
    wait8(n);
    check({nm, "_latency"}, 64'(n + 1), 64'd9);
    check(nm, 64'(prod8), 64'(exp));
    $display("txn %s: %0h x %0h signed=%0d -> %0h", nm, a, b, s, prod8);
  endtask

  task automatic run32(input string nm, input bit s, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input logic exp_x);
    int n;
    @(negedge clk); st32 = 1'b1; sg32 = s; a32 = a; b32 = b;
    @(negedge clk); st32 = 1'b0;
    wait32(n);
    check({nm, "_latency"}, 64'(n + 1), 64'd33);
    check(nm, prod32, exp);
    check({nm, "_x"}, 64'(x32), 64'(exp_x));
    $display("txn %s: %0h x %0h signed=%0d -> %0h", nm, a, b, s, prod32);
  endtask

  initial begin
    int n;
    check("model_7xm59", model_mul(8, 32'h07, 32'hC5, 1'b1), 64'hFE63);
    check("model_u_ffff", model_mul(32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0),
          64'hFFFF_FFFE_0000_0001);

    repeat (2) @(negedge clk);
    check("rst_prod8", 64'(prod8), 64'd0);
    check("rst_busy8", 64'(busy8), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run8("s_7xm59", 1'b1, 8'h07, 8'hC5, 16'hFE63);
    run8("s_m128sq", 1'b1, 8'h80, 8'h80, 16'h4000);
    run8("u_ffxff", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
    run32("s32_m1xm1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1, 1'b0);
    run32("u32_ffxff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);

    // start held high through RUN while operands change
    @(negedge clk); st8 = 1'b1; sg8 = 1'b0; a8 = 8'd3; b8 = 8'd5;
    @(negedge clk); a8 = 8'd9; b8 = 8'd9; sg8 = 1'b1;
    repeat (4) @(negedge clk);
    st8 = 1'b0;
    wait8(n);
    check("hold_start", 64'(prod8), 64'd15);
    $display("txn hold_start: 3 x 5 -> %0h", prod8);

    // back-to-back: new start presented during the DONE cycle
    run8("b2b_first", 1'b1, 8'hFD, 8'h04, 16'hFFF4);
    st8 = 1'b1; sg8 = 1'b0; a8 = 8'd12; b8 = 8'd11;
    @(posedge clk); #1;
    st8 = 1'b0;
    wait8(n);
    check("b2b_latency", 64'(n + 1), 64'd9);
    check("b2b_second", 64'(prod8), 64'd132);
    $display("txn b2b_second: 12 x 11 -> %0h", prod8);

    // asynchronous reset mid-RUN
    @(negedge clk); st8 = 1'b1; sg8 = 1'b1; a8 = 8'h55; b8 = 8'hAA;
    @(negedge clk); st8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy8), 64'd0);
    check("arst_done", 64'(done8), 64'd0);
    check("arst_prod", 64'(prod8), 64'd0);
    check("arst_x", 64'(x8), 64'd0);
    $display("txn async_reset: busy=%0d prod=%0h", busy8, prod8);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    run8("z_0x7f", 1'b0, 8'h00, 8'h7F, 16'h0000);
    @(posedge clk); #1;
    check("z1_done_pulse", 64'(done8), 64'd0);
    check("z1_busy_after", 64'(busy8), 64'd0);
    run8("z_7fx0", 1'b1, 8'h7F, 8'h00, 16'h0000);
    @(posedge clk); #1;
    check("z2_done_pulse", 64'(done8), 64'd0);
    check("z2_busy_after", 64'(busy8), 64'd0);
    run8("post_rst_s", 1'b1, 8'hF6, 8'h0D, 16'hFF7E);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
